// File: rtl/cordic_pkg.sv
// Shared constants and types for the pipelined sine/cosine CORDIC.
// The arctangent, gain and pi constants are stored at 2^-30 resolution.
// They are rounded to the fractional width FRAC of the instantiating pipeline.
// Contents:
//   fold_flags_t   side-band record (neg, err, valid) carried down the pipe
//   atan_q(i,frac) atan(2^-i) scaled by 2^frac, rounded, i = 0..31
//   k_q / pi_q / half_pi_q  CORDIC gain compensation, pi and pi/2 at 2^frac
package cordic_pkg;

  localparam int TABLE_FRAC = 30;

  typedef struct packed {
    logic neg;
    logic err;
    logic valid;
  } fold_flags_t;

  // Rescales a 2^-30 constant to 2^-frac, rounding half up.
  function automatic longint round_shift(input longint v, input int frac);
    if (frac >= TABLE_FRAC)
      return v <<< (frac - TABLE_FRAC);
    return (v + (longint'(1) <<< (TABLE_FRAC - frac - 1))) >>> (TABLE_FRAC - frac);
  endfunction

  // Beyond i = 9 the cubic term of atan(x) is below half an LSB at 2^-30,
  // so atan(2^-i) is simply 2^(30-i).
  function automatic longint atan_raw(input int i);
    case (i)
      0: return 64'sh3243F6A8;
      1: return 64'sh1DAC6705;
      2: return 64'sh0FADBAFC;
      3: return 64'sh07F56EA6;
      4: return 64'sh03FEAB76;
      5: return 64'sh01FFD55B;
      6: return 64'sh00FFFAAA;
      7: return 64'sh007FFF55;
      8: return 64'sh003FFFEA;
      9: return 64'sh001FFFFD;
      default: return (i <= 30) ? (longint'(1) <<< (30 - i)) : longint'(0);
    endcase
  endfunction

  function automatic longint atan_q(input int i, input int frac);
    return round_shift(atan_raw(i), frac);
  endfunction

  function automatic longint k_q(input int frac);
    return round_shift(64'sd652032874, frac);
  endfunction

  function automatic longint pi_q(input int frac);
    return round_shift(64'sd3373259426, frac);
  endfunction

  function automatic longint half_pi_q(input int frac);
    return round_shift(64'sd1686629713, frac);
  endfunction

endpackage

// File: rtl/cordic_sincos_pipe_if.sv
// Sample-stream interface between the angle source, the CORDIC pipeline
// and the downstream consumer.
//   in_valid, angle_in              : angle source -> pipeline
//   out_valid, sin_out, cos_out,
//   range_err                       : pipeline -> consumer
// master modport belongs to the source/consumer side and slave modport to the pipeline.
interface cordic_sincos_pipe_if #(
  parameter int WIDTH = 22
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] angle_in;
  logic                    out_valid;
  logic signed [WIDTH-1:0] sin_out;
  logic signed [WIDTH-1:0] cos_out;
  logic                    range_err;

  modport master (
    output in_valid, angle_in,
    input  out_valid, sin_out, cos_out, range_err
  );

  modport slave (
    input  in_valid, angle_in,
    output out_valid, sin_out, cos_out, range_err
  );
endinterface

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation in rotation mode.
// The rotation direction comes from the sign of the residual angle z.
// Ports:
//   clk, reset (sync, active-high), enable (clock enable)
//   x_in/y_in/z_in   -> x_out/y_out/z_out  vector and residual angle
//   flags_in         -> flags_out          side-band, passed unchanged
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                          WIDTH_INT = 24,
  parameter int                          SHIFT     = 0,
  parameter logic signed [WIDTH_INT-1:0] ATAN_VAL  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic signed [WIDTH_INT-1:0] x_in,
  input  logic signed [WIDTH_INT-1:0] y_in,
  input  logic signed [WIDTH_INT-1:0] z_in,
  input  fold_flags_t                 flags_in,
  output logic signed [WIDTH_INT-1:0] x_out,
  output logic signed [WIDTH_INT-1:0] y_out,
  output logic signed [WIDTH_INT-1:0] z_out,
  output fold_flags_t                 flags_out
);

  logic signed [WIDTH_INT-1:0] x_shift;
  logic signed [WIDTH_INT-1:0] y_shift;

  assign x_shift = x_in >>> SHIFT;
  assign y_shift = y_in >>> SHIFT;

  // z >= 0 rotates counter-clockwise (d = +1); negative z rotates back.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      flags_out <= '0;
    end else if (enable) begin
      if (!z_in[WIDTH_INT-1]) begin
        x_out <= x_in - y_shift;
        y_out <= y_in + x_shift;
        z_out <= z_in - ATAN_VAL;
      end else begin
        x_out <= x_in + y_shift;
        y_out <= y_in - x_shift;
        z_out <= z_in + ATAN_VAL;
      end
      flags_out <= flags_in;
    end
  end

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully unrolled, pipelined CORDIC that produces sine and cosine of one
// angle per enabled clock. Angles in (pi/2, pi] or [-pi, -pi/2) are folded
// by pi into the convergent range, and the result is negated afterwards.
// The pipeline has one fold register, STAGES rotation registers and one output register.
// Ports:
//   clk, reset (sync, active-high), enable (global stall when low)
//   bus.in_valid, bus.angle_in            : input sample, Q(WIDTH-FRAC).FRAC radians
//   bus.out_valid, bus.sin_out, bus.cos_out, bus.range_err : result
module cordic_sincos_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int FRAC   = 19,
  parameter int STAGES = 16
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 enable,
  cordic_sincos_pipe_if.slave bus
);

  // Two guard bits keep the folded angle and the CORDIC growth from wrapping.
  localparam int WI = WIDTH + 2;

  localparam logic signed [WI-1:0] K_I       = WI'(k_q(FRAC));
  localparam logic signed [WI-1:0] PI_I      = WI'(pi_q(FRAC));
  localparam logic signed [WI-1:0] HALF_PI_I = WI'(half_pi_q(FRAC));
  localparam logic signed [WI-1:0] SAT_MAX   = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WI-1:0] SAT_MIN   = {3'b111, {(WIDTH-1){1'b0}}};

  logic signed [WI-1:0] x_pipe [0:STAGES];
  logic signed [WI-1:0] y_pipe [0:STAGES];
  logic signed [WI-1:0] z_pipe [0:STAGES];
  fold_flags_t          flags_pipe [0:STAGES];

  logic signed [WI-1:0] x0, y0, z0;
  fold_flags_t          flags0;
  logic signed [WI-1:0] angle_ext;
  logic signed [WI-1:0] x_fin, y_fin;

  assign angle_ext = {{2{bus.angle_in[WIDTH-1]}}, bus.angle_in};

  // Fold register: reflect angles outside +/-pi/2 through pi and remember to
  // negate the result. Exactly +/-pi takes the fold branch and is not an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0     <= '0;
      y0     <= '0;
      z0     <= '0;
      flags0 <= '0;
    end else if (enable) begin
      x0 <= K_I;
      y0 <= '0;
      if (angle_ext > HALF_PI_I) begin
        z0         <= angle_ext - PI_I;
        flags0.neg <= 1'b1;
      end else if (angle_ext < -HALF_PI_I) begin
        z0         <= angle_ext + PI_I;
        flags0.neg <= 1'b1;
      end else begin
        z0         <= angle_ext;
        flags0.neg <= 1'b0;
      end
      flags0.err   <= (angle_ext > PI_I) || (angle_ext < -PI_I);
      flags0.valid <= bus.in_valid;
    end
  end

  assign x_pipe[0]     = x0;
  assign y_pipe[0]     = y0;
  assign z_pipe[0]     = z0;
  assign flags_pipe[0] = flags0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .WIDTH_INT (WI),
      .SHIFT     (i),
      .ATAN_VAL  (WI'(atan_q(i, FRAC)))
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .x_in      (x_pipe[i]),
      .y_in      (y_pipe[i]),
      .z_in      (z_pipe[i]),
      .flags_in  (flags_pipe[i]),
      .x_out     (x_pipe[i+1]),
      .y_out     (y_pipe[i+1]),
      .z_out     (z_pipe[i+1]),
      .flags_out (flags_pipe[i+1])
    );
  end

  // Undo the fold: rotating by pi negates both components.
  always_comb begin
    x_fin = x_pipe[STAGES];
    y_fin = y_pipe[STAGES];
    if (flags_pipe[STAGES].neg) begin
      x_fin = -x_pipe[STAGES];
      y_fin = -y_pipe[STAGES];
    end
  end

  function automatic logic [WIDTH-1:0] saturate(input logic signed [WI-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > SAT_MAX)
      r = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN)
      r = SAT_MIN[WIDTH-1:0];
    else
      r = v[WIDTH-1:0];
    return r;
  endfunction

  // The output register aligns the data with out_valid and range_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.range_err <= 1'b0;
      bus.cos_out   <= '0;
      bus.sin_out   <= '0;
    end else if (enable) begin
      bus.out_valid <= flags_pipe[STAGES].valid;
      bus.range_err <= flags_pipe[STAGES].err;
      bus.cos_out   <= saturate(x_fin);
      bus.sin_out   <= saturate(y_fin);
    end
  end

endmodule
